// File: rtl/prog_loader.sv
// Byte-serial program loader: parses header/address/count framed byte streams into
// instruction words and issues one registered write strobe per word.
module prog_loader #(
  parameter int unsigned CORES       = 8,
  parameter int unsigned LOG_CORES   = 3,
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   we,
  output logic [LOG_CORES-1:0]   sel,
  output logic [PC_WIDTH-1:0]    waddr,
  output logic [INSTR_WIDTH-1:0] wdata,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err
);

  localparam int unsigned Bytes = INSTR_WIDTH / 8;
  localparam int unsigned BcW   = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam logic [BcW-1:0] BcLast = BcW'(Bytes - 1);

  typedef enum logic [1:0] {StHdr, StAdr, StCnt, StDat} state_e;

  state_e                 state_q, state_d;
  logic [LOG_CORES-1:0]   core_q, core_d;
  logic                   bad_q, bad_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic [7:0]             wcnt_q, wcnt_d;
  logic [BcW-1:0]         bcnt_q, bcnt_d;
  logic [INSTR_WIDTH-1:0] sr_q, sr_d;
  logic                   we_q, we_d;
  logic [LOG_CORES-1:0]   sel_q, sel_d;
  logic [PC_WIDTH-1:0]    waddr_q, waddr_d;
  logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   accept;

  assign in_ready = enable;
  assign accept   = in_valid & enable;

  always_comb begin
    state_d = state_q;
    core_d  = core_q;
    bad_d   = bad_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    sr_d    = sr_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    sel_d   = sel_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (accept) begin
      unique case (state_q)
        StHdr: begin
          core_d  = in_data[LOG_CORES-1:0];
          bad_d   = (32'(in_data[LOG_CORES-1:0]) >= CORES);
          err_d   = bad_d;
          state_d = StAdr;
        end
        StAdr: begin
          addr_d  = in_data[PC_WIDTH-1:0];
          state_d = StCnt;
        end
        StCnt: begin
          wcnt_d  = in_data;
          bcnt_d  = '0;
          state_d = StDat;
        end
        StDat: begin
          // Shift from the LSB end so the first (most significant) byte ends up on top.
          sr_d = (sr_q << 8) | INSTR_WIDTH'(in_data);
          if (bcnt_q == BcLast) begin
            bcnt_d = '0;
            we_d   = ~bad_q;
            done_d = (wcnt_q == 8'd0);
            if (!bad_q) begin
              sel_d   = core_q;
              waddr_d = addr_q;
              wdata_d = sr_d;
            end
            addr_d = addr_q + PC_WIDTH'(1);
            if (wcnt_q == 8'd0) begin
              state_d = StHdr;
            end else begin
              wcnt_d = wcnt_q - 8'd1;
            end
          end else begin
            bcnt_d = bcnt_q + BcW'(1);
          end
        end
        default: state_d = StHdr;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StHdr;
      core_q  <= '0;
      bad_q   <= 1'b0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      sr_q    <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      bad_q   <= bad_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      sr_q    <= sr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign we         = we_q;
  assign sel        = sel_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign busy       = (state_q != StHdr);
  assign frame_done = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a 32-bit/8-core instance and an 8-bit/6-core instance,
// each checked against a frame-level model of expected write/frame_done events.
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic        a_en, a_valid, a_ready, a_we, a_busy, a_done, a_err;
  logic [7:0]  a_data, a_waddr;
  logic [2:0]  a_sel;
  logic [31:0] a_wdata;

  logic        b_en, b_valid, b_ready, b_we, b_busy, b_done, b_err;
  logic [7:0]  b_data, b_waddr, b_wdata;
  logic [2:0]  b_sel;

  prog_loader #(.CORES(8), .LOG_CORES(3), .PC_WIDTH(8), .INSTR_WIDTH(32)) u_a (
    .clk(clk), .rst(rst), .enable(a_en), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready), .we(a_we), .sel(a_sel), .waddr(a_waddr), .wdata(a_wdata),
    .busy(a_busy), .frame_done(a_done), .err(a_err)
  );

  prog_loader #(.CORES(6), .LOG_CORES(3), .PC_WIDTH(8), .INSTR_WIDTH(8)) u_b (
    .clk(clk), .rst(rst), .enable(b_en), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .we(b_we), .sel(b_sel), .waddr(b_waddr), .wdata(b_wdata),
    .busy(b_busy), .frame_done(b_done), .err(b_err)
  );

  typedef struct {
    bit          we;
    bit          done;
    int unsigned sel;
    int unsigned addr;
    logic [63:0] data;
    int          cyc;
  } ev_t;

  ev_t obs_a[$], exp_a[$], obs_b[$], exp_b[$];

  // Every cycle carrying a write or a frame_done becomes one observed event.
  always @(negedge clk) begin
    if (a_we || a_done)
      obs_a.push_back('{a_we, a_done, 32'(a_sel), 32'(a_waddr), 64'(a_wdata), cyc});
    if (b_we || b_done)
      obs_b.push_back('{b_we, b_done, 32'(b_sel), 32'(b_waddr), 64'(b_wdata), cyc});
  end

  function automatic string ev_fmt(input ev_t e);
    return $sformatf("we=%0b done=%0b sel=%0d addr=%02h data=%0h", e.we, e.done, e.sel,
                     e.addr, e.data);
  endfunction

  task automatic a_put(input logic [7:0] b, input int gap);
    a_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    a_valid = 1'b1;
    a_data  = b;
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic b_put(input logic [7:0] b, input int gap);
    b_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    b_valid = 1'b1;
    b_data  = b;
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  // Model: one write per word unless the select is out of range; frame_done on the last word.
  task automatic a_send_frame(input logic [7:0] hdr, input logic [7:0] adr,
                              input logic [31:0] words[$], input int maxgap);
    int unsigned s;
    bit          bad;
    int          n;
    logic [31:0] w;
    s   = 32'(hdr[2:0]);
    bad = (s >= 8);
    n   = words.size();
    a_put(hdr, $urandom_range(0, maxgap));
    a_put(adr, $urandom_range(0, maxgap));
    a_put(8'(n - 1), $urandom_range(0, maxgap));
    for (int i = 0; i < n; i++) begin
      w = words[i];
      if (!bad || i == n - 1)
        exp_a.push_back('{!bad, i == n - 1, s, (32'(adr) + i) % 256, 64'(w), 0});
      for (int k = 3; k >= 0; k--) a_put(w[8*k +: 8], $urandom_range(0, maxgap));
    end
  endtask

  task automatic b_send_frame(input logic [7:0] hdr, input logic [7:0] adr,
                              input logic [7:0] words[$], input int maxgap);
    int unsigned s;
    bit          bad;
    int          n;
    s   = 32'(hdr[2:0]);
    bad = (s >= 6);
    n   = words.size();
    b_put(hdr, $urandom_range(0, maxgap));
    b_put(adr, $urandom_range(0, maxgap));
    b_put(8'(n - 1), $urandom_range(0, maxgap));
    for (int i = 0; i < n; i++) begin
      if (!bad || i == n - 1)
        exp_b.push_back('{!bad, i == n - 1, s, (32'(adr) + i) % 256, 64'(words[i]), 0});
      b_put(words[i], $urandom_range(0, maxgap));
    end
  endtask

  task automatic test_reset;
    n_vec++;
    if ({a_we, a_sel, a_waddr, a_wdata, a_busy, a_done, a_err} !== '0) begin
      n_err++;
      $display("FAIL reset_a got we=%b sel=%h waddr=%h wdata=%h busy=%b done=%b err=%b want all 0",
               a_we, a_sel, a_waddr, a_wdata, a_busy, a_done, a_err);
    end
    n_vec++;
    if ({b_we, b_sel, b_waddr, b_wdata, b_busy, b_done, b_err} !== '0) begin
      n_err++;
      $display("FAIL reset_b got we=%b sel=%h waddr=%h wdata=%h busy=%b done=%b err=%b want all 0",
               b_we, b_sel, b_waddr, b_wdata, b_busy, b_done, b_err);
    end
    n_vec++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready got %b%b want 11", a_ready, b_ready);
    end
  endtask

  task automatic test_basic;
    logic [7:0] bytes[8];
    bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    exp_a.push_back('{1'b1, 1'b0, 2, 8'h10, 64'hDEADBEEF, 0});
    exp_a.push_back('{1'b1, 1'b1, 2, 8'h11, 64'h01234567, 0});
    a_put(8'h02, 0);
    n_vec++;
    if (a_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_hi got %b want 1", a_busy); end
    a_put(8'h10, 0);
    a_put(8'h01, 0);
    for (int i = 0; i < 8; i++) begin
      a_put(bytes[i], 0);
      if (i == 3) begin
        n_vec++;
        if (a_we !== 1'b1 || a_wdata !== 32'hDEADBEEF || a_done !== 1'b0) begin
          n_err++;
          $display("FAIL basic_latency got we=%b wdata=%h done=%b want 1 deadbeef 0",
                   a_we, a_wdata, a_done);
        end
      end
    end
    n_vec++;
    if (a_we !== 1'b1 || a_done !== 1'b1 || a_busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_last got we=%b done=%b busy=%b want 1 1 0", a_we, a_done, a_busy);
    end
    repeat (3) begin @(posedge clk); #1; end
    n_vec++;
    if (obs_a.size() != exp_a.size()) begin
      n_err++;
      $display("FAIL basic_count got %0d want %0d", obs_a.size(), exp_a.size());
    end
    foreach (exp_a[i]) if (i < obs_a.size()) begin
      n_vec++;
      if (obs_a[i].we !== exp_a[i].we || obs_a[i].done !== exp_a[i].done || (exp_a[i].we &&
          (obs_a[i].sel != exp_a[i].sel || obs_a[i].addr != exp_a[i].addr ||
           obs_a[i].data !== exp_a[i].data))) begin
        n_err++;
        $display("FAIL basic_ev%0d got %s want %s", i, ev_fmt(obs_a[i]), ev_fmt(exp_a[i]));
      end
    end
    n_vec++;
    if (obs_a.size() == 2 && obs_a[1].cyc - obs_a[0].cyc != 4) begin
      n_err++;
      $display("FAIL basic_period got %0d want 4", obs_a[1].cyc - obs_a[0].cyc);
    end
    obs_a.delete(); exp_a.delete();
  endtask

  task automatic test_wrap_and_max;
    logic [31:0] w[$];
    bit          seen[256];
    int          distinct;
    repeat (3) w.push_back($urandom);
    a_send_frame(8'h07, 8'hFE, w, 1);
    w.delete();
    repeat (256) w.push_back($urandom);
    a_send_frame(8'h03, 8'($urandom), w, 0);
    repeat (3) begin @(posedge clk); #1; end
    n_vec++;
    if (obs_a.size() != exp_a.size()) begin
      n_err++;
      $display("FAIL wrap_count got %0d want %0d", obs_a.size(), exp_a.size());
    end
    foreach (exp_a[i]) if (i < obs_a.size()) begin
      n_vec++;
      if (obs_a[i].we !== exp_a[i].we || obs_a[i].done !== exp_a[i].done || (exp_a[i].we &&
          (obs_a[i].sel != exp_a[i].sel || obs_a[i].addr != exp_a[i].addr ||
           obs_a[i].data !== exp_a[i].data))) begin
        n_err++;
        $display("FAIL wrap_ev%0d got %s want %s", i, ev_fmt(obs_a[i]), ev_fmt(exp_a[i]));
      end
    end
    distinct = 0;
    for (int i = 3; i < obs_a.size(); i++) begin
      if (!seen[obs_a[i].addr % 256]) distinct++;
      seen[obs_a[i].addr % 256] = 1'b1;
    end
    n_vec++;
    if (distinct != 256 || obs_a.size() != 259) begin
      n_err++;
      $display("FAIL max_cover got %0d distinct of %0d writes want 256 of 256", distinct,
               obs_a.size() - 3);
    end
    obs_a.delete(); exp_a.delete();
  endtask

  task automatic test_stall;
    logic [31:0] w[$];
    logic [31:0] w0;
    int          sel_r;
    sel_r = $urandom_range(0, 7);
    repeat (2) w.push_back($urandom);
    w0 = w[0];
    exp_a.push_back('{1'b1, 1'b0, sel_r, 8'h40, 64'(w[0]), 0});
    exp_a.push_back('{1'b1, 1'b1, sel_r, 8'h41, 64'(w[1]), 0});
    a_put(8'(sel_r), 2);
    a_put(8'h40, 0);
    a_put(8'h01, 3);
    a_put(w0[31:24], 2);
    a_put(w0[23:16], 0);
    a_valid = 1'b1;
    a_data  = w0[15:8];
    a_en    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if (a_ready !== 1'b0 || a_busy !== 1'b1 || a_we !== 1'b0) begin
        n_err++;
        $display("FAIL stall_c%0d got ready=%b busy=%b we=%b want 0 1 0", c, a_ready, a_busy,
                 a_we);
      end
    end
    a_en = 1'b1;
    #1;
    n_vec++;
    if (a_ready !== 1'b1) begin n_err++; $display("FAIL stall_resume got %b want 1", a_ready); end
    a_put(w0[15:8], 0);
    a_put(w0[7:0], 1);
    w0 = w[1];
    for (int k = 3; k >= 0; k--) a_put(w0[8*k +: 8], $urandom_range(0, 3));
    for (int f = 0; f < 4; f++) begin
      w.delete();
      repeat ($urandom_range(1, 6)) w.push_back($urandom);
      a_send_frame(8'($urandom), 8'($urandom), w, (f % 2) * 3);
    end
    repeat (3) begin @(posedge clk); #1; end
    n_vec++;
    if (obs_a.size() != exp_a.size()) begin
      n_err++;
      $display("FAIL stall_count got %0d want %0d", obs_a.size(), exp_a.size());
    end
    foreach (exp_a[i]) if (i < obs_a.size()) begin
      n_vec++;
      if (obs_a[i].we !== exp_a[i].we || obs_a[i].done !== exp_a[i].done || (exp_a[i].we &&
          (obs_a[i].sel != exp_a[i].sel || obs_a[i].addr != exp_a[i].addr ||
           obs_a[i].data !== exp_a[i].data))) begin
        n_err++;
        $display("FAIL stall_ev%0d got %s want %s", i, ev_fmt(obs_a[i]), ev_fmt(exp_a[i]));
      end
    end
    obs_a.delete(); exp_a.delete();
  endtask

  task automatic test_reset_mid;
    logic [31:0] w[$];
    a_put(8'h01, 0);
    a_put(8'h20, 0);
    a_put(8'h00, 0);
    a_put(8'hAA, 0);
    a_put(8'hBB, 0);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({a_we, a_sel, a_waddr, a_wdata, a_busy, a_done, a_err} !== '0) begin
      n_err++;
      $display("FAIL rstmid_async got we=%b sel=%h waddr=%h wdata=%h busy=%b done=%b err=%b want 0",
               a_we, a_sel, a_waddr, a_wdata, a_busy, a_done, a_err);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    repeat (2) w.push_back($urandom);
    a_send_frame(8'h05, 8'h30, w, 1);
    repeat (3) begin @(posedge clk); #1; end
    n_vec++;
    if (obs_a.size() != exp_a.size()) begin
      n_err++;
      $display("FAIL rstmid_count got %0d want %0d", obs_a.size(), exp_a.size());
    end
    foreach (exp_a[i]) if (i < obs_a.size()) begin
      n_vec++;
      if (obs_a[i].we !== exp_a[i].we || obs_a[i].done !== exp_a[i].done || (exp_a[i].we &&
          (obs_a[i].sel != exp_a[i].sel || obs_a[i].addr != exp_a[i].addr ||
           obs_a[i].data !== exp_a[i].data))) begin
        n_err++;
        $display("FAIL rstmid_ev%0d got %s want %s", i, ev_fmt(obs_a[i]), ev_fmt(exp_a[i]));
      end
    end
    obs_a.delete(); exp_a.delete();
  endtask

  task automatic test_bad_select;
    logic [7:0] w[$];
    w.push_back(8'($urandom));
    b_put(8'h06, 0);
    n_vec++;
    if (b_err !== 1'b1) begin n_err++; $display("FAIL bad_err_rise got %b want 1", b_err); end
    exp_b.push_back('{1'b0, 1'b1, 6, 0, 64'(w[0]), 0});
    b_put(8'h00, 0);
    b_put(8'h00, 1);
    b_put(w[0], 0);
    n_vec++;
    if (b_err !== 1'b1 || b_we !== 1'b0 || b_done !== 1'b1) begin
      n_err++;
      $display("FAIL bad_end got err=%b we=%b done=%b want 1 0 1", b_err, b_we, b_done);
    end
    b_put(8'h01, 2);
    n_vec++;
    if (b_err !== 1'b0) begin n_err++; $display("FAIL bad_err_clear got %b want 0", b_err); end
    b_put(8'h50, 0);
    b_put(8'h01, 0);
    exp_b.push_back('{1'b1, 1'b0, 1, 8'h50, 64'h5A, 0});
    exp_b.push_back('{1'b1, 1'b1, 1, 8'h51, 64'hC3, 0});
    b_put(8'h5A, 0);
    b_put(8'hC3, 1);
    w.delete();
    repeat (3) w.push_back(8'($urandom));
    b_send_frame(8'h0F, 8'h10, w, 2);
    n_vec++;
    if (b_err !== 1'b1) begin n_err++; $display("FAIL bad_err_hold got %b want 1", b_err); end
    repeat (3) begin @(posedge clk); #1; end
    n_vec++;
    if (obs_b.size() != exp_b.size()) begin
      n_err++;
      $display("FAIL bad_count got %0d want %0d", obs_b.size(), exp_b.size());
    end
    foreach (exp_b[i]) if (i < obs_b.size()) begin
      n_vec++;
      if (obs_b[i].we !== exp_b[i].we || obs_b[i].done !== exp_b[i].done || (exp_b[i].we &&
          (obs_b[i].sel != exp_b[i].sel || obs_b[i].addr != exp_b[i].addr ||
           obs_b[i].data !== exp_b[i].data))) begin
        n_err++;
        $display("FAIL bad_ev%0d got %s want %s", i, ev_fmt(obs_b[i]), ev_fmt(exp_b[i]));
      end
    end
    obs_b.delete(); exp_b.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] w[$];
    repeat (4) w.push_back(8'($urandom));
    b_send_frame(8'h03, 8'h10, w, 0);
    w.delete();
    repeat (4) w.push_back(8'($urandom));
    b_send_frame(8'h05, 8'h80, w, 0);
    repeat (3) begin @(posedge clk); #1; end
    n_vec++;
    if (obs_b.size() != exp_b.size()) begin
      n_err++;
      $display("FAIL b2b_count got %0d want %0d", obs_b.size(), exp_b.size());
    end
    foreach (exp_b[i]) if (i < obs_b.size()) begin
      n_vec++;
      if (obs_b[i].we !== exp_b[i].we || obs_b[i].done !== exp_b[i].done || (exp_b[i].we &&
          (obs_b[i].sel != exp_b[i].sel || obs_b[i].addr != exp_b[i].addr ||
           obs_b[i].data !== exp_b[i].data))) begin
        n_err++;
        $display("FAIL b2b_ev%0d got %s want %s", i, ev_fmt(obs_b[i]), ev_fmt(exp_b[i]));
      end
    end
    // Words within a frame land on consecutive cycles; the next frame costs only its 3 header bytes.
    for (int i = 1; i < obs_b.size() && i < 8; i++) begin
      n_vec++;
      if (obs_b[i].cyc - obs_b[i-1].cyc != ((i == 4) ? 4 : 1)) begin
        n_err++;
        $display("FAIL b2b_gap%0d got %0d want %0d", i, obs_b[i].cyc - obs_b[i-1].cyc,
                 (i == 4) ? 4 : 1);
      end
    end
    obs_b.delete(); exp_b.delete();
  endtask

  initial begin
    rst     = 1'b1;
    a_en    = 1'b1;
    a_valid = 1'b0;
    a_data  = 8'h00;
    b_en    = 1'b1;
    b_valid = 1'b0;
    b_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    test_basic;
    test_wrap_and_max;
    test_stall;
    test_reset_mid;
    test_bad_select;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
